control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 177 +++++++++++++++++
 tb/tb_control_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Multicycle RISC-V control unit. A state register walks each instruction
// through fetch, decode and execute. The datapath controls are decoded from
// the current state, plus the mem_ready and branch_cond qualifiers.
// Write enables and illegal_instr are held low while reset is high.
module control_unit #(
  parameter int PRINT_STATE = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       branch_cond,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [4:0] alu_control,
  output logic [2:0] imm_src,
  output logic       illegal_instr,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
    S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_JALR = 4'd11
  } state_t;

  localparam logic [4:0] ALU_ADD = 5'b00000, ALU_SUB = 5'b00001, ALU_AND = 5'b00010,
                         ALU_RA  = 5'b00011, ALU_OR  = 5'b00100, ALU_XOR = 5'b00101,
                         ALU_LS  = 5'b00110, ALU_RS  = 5'b00111, ALU_EQ  = 5'b01001,
                         ALU_NEQ = 5'b01010, ALU_LT  = 5'b01011, ALU_LTS = 5'b01101,
                         ALU_GE  = 5'b01111, ALU_GES = 5'b10000;

  state_t r_state;

  logic w_is_load, w_is_store, w_is_r, w_is_i, w_is_lui, w_is_auipc;
  logic w_is_br, w_is_jal, w_is_jalr, w_br_bad;
  logic [4:0] w_arith_op, w_branch_op;
  logic w_pc_write, w_mem_write, w_ir_write, w_reg_write, w_illegal;

  assign w_is_load  = (opcode == 7'b0000011);
  assign w_is_store = (opcode == 7'b0100011);
  assign w_is_r     = (opcode == 7'b0110011);
  assign w_is_i     = (opcode == 7'b0010011);
  assign w_is_lui   = (opcode == 7'b0110111);
  assign w_is_auipc = (opcode == 7'b0010111);
  assign w_is_br    = (opcode == 7'b1100011);
  assign w_is_jal   = (opcode == 7'b1101111);
  assign w_is_jalr  = (opcode == 7'b1100111);
  // funct3 010/011 have no branch meaning
  assign w_br_bad   = (funct3 == 3'b010) || (funct3 == 3'b011);

  // State register: advance on the instruction class and memory handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:    if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          if (w_is_load || w_is_store)               r_state <= S_MEMADR;
          else if (w_is_r)                           r_state <= S_EXECR;
          else if (w_is_i || w_is_lui || w_is_auipc) r_state <= S_EXECI;
          else if (w_is_br)                          r_state <= S_BRANCH;
          else if (w_is_jal)                         r_state <= S_JAL;
          else if (w_is_jalr)                        r_state <= S_JALR;
          else                                       r_state <= S_FETCH;
        end
        S_MEMADR:   r_state <= w_is_load ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (mem_ready) r_state <= S_MEMWB;
        S_MEMWB:    r_state <= S_FETCH;
        S_MEMWRITE: if (mem_ready) r_state <= S_FETCH;
        S_EXECR:    r_state <= S_ALUWB;
        S_EXECI:    r_state <= S_ALUWB;
        S_ALUWB:    r_state <= S_FETCH;
        S_BRANCH:   r_state <= S_FETCH;
        S_JAL:      r_state <= S_ALUWB;
        S_JALR:     r_state <= S_JAL;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  // ALU operation for R-type and I-type arithmetic, and for branch compares
  always_comb begin
    w_arith_op = ALU_ADD;
    case (funct3)
      3'b000: w_arith_op = (r_state == S_EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001: w_arith_op = ALU_LS;
      3'b010: w_arith_op = ALU_LTS;
      3'b011: w_arith_op = ALU_LT;
      3'b100: w_arith_op = ALU_XOR;
      3'b101: w_arith_op = funct7b5 ? ALU_RA : ALU_RS;
      3'b110: w_arith_op = ALU_OR;
      default: w_arith_op = ALU_AND;
    endcase
    w_branch_op = ALU_ADD;
    case (funct3)
      3'b000: w_branch_op = ALU_EQ;
      3'b001: w_branch_op = ALU_NEQ;
      3'b100: w_branch_op = ALU_LTS;
      3'b101: w_branch_op = ALU_GES;
      3'b110: w_branch_op = ALU_LT;
      3'b111: w_branch_op = ALU_GE;
      default: w_branch_op = ALU_ADD;
    endcase
  end

  // Per-state datapath controls; anything not set for a state stays 0
  always_comb begin
    w_pc_write = 1'b0; w_mem_write = 1'b0; w_ir_write = 1'b0; w_reg_write = 1'b0;
    w_illegal = 1'b0; adr_src = 1'b0; result_src = 2'b00; alu_src_a = 2'b00;
    alu_src_b = 2'b00; alu_control = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        alu_src_b = 2'b10; result_src = 2'b10;
        w_ir_write = mem_ready; w_pc_write = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01; alu_src_b = 2'b01;
        w_illegal = !(w_is_load || w_is_store || w_is_r || w_is_i || w_is_lui ||
                      w_is_auipc || w_is_br || w_is_jal || w_is_jalr);
      end
      S_MEMADR:   begin alu_src_a = 2'b10; alu_src_b = 2'b01; end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB:    begin result_src = 2'b01; w_reg_write = 1'b1; end
      S_MEMWRITE: begin adr_src = 1'b1; w_mem_write = 1'b1; end
      S_EXECR:    begin alu_src_a = 2'b10; alu_control = w_arith_op; end
      S_EXECI: begin
        alu_src_b   = 2'b01;
        alu_src_a   = w_is_lui ? 2'b11 : (w_is_auipc ? 2'b01 : 2'b10);
        alu_control = (w_is_lui || w_is_auipc) ? ALU_ADD : w_arith_op;
      end
      S_ALUWB:    w_reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = w_branch_op;
        w_pc_write  = branch_cond && !w_br_bad;
        w_illegal   = w_br_bad;
      end
      S_JAL:      begin alu_src_a = 2'b01; alu_src_b = 2'b10; w_pc_write = 1'b1; end
      S_JALR:     begin alu_src_a = 2'b10; alu_src_b = 2'b01; end
      default:    w_illegal = 1'b0;
    endcase
  end

  // Immediate format follows the opcode directly
  always_comb begin
    imm_src = 3'b000;
    if (w_is_store)                   imm_src = 3'b001;
    else if (w_is_br)                 imm_src = 3'b010;
    else if (w_is_jal)                imm_src = 3'b011;
    else if (w_is_lui || w_is_auipc)  imm_src = 3'b100;
  end

  assign pc_write      = w_pc_write  & ~reset;
  assign mem_write     = w_mem_write & ~reset;
  assign ir_write      = w_ir_write  & ~reset;
  assign reg_write     = w_reg_write & ~reset;
  assign illegal_instr = w_illegal   & ~reset;
  assign state_dbg     = r_state;

`ifndef SYNTHESIS
  // Optional trace of state transitions by name
  always @(r_state) begin
    if (PRINT_STATE != 0) $display("control_unit state -> %s", r_state.name());
  end
`endif

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a vector table of instructions with known cycle
// counts and ALU codes, directed stall/reset sequences, and randomized
// instructions with random memory stalls checked cycle-by-cycle against a
// model that expands each instruction into its expected state path.
module tb_control_unit;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4,
                 S_MEMWRITE = 5, S_EXECR = 6, S_EXECI = 7, S_ALUWB = 8, S_BRANCH = 9,
                 S_JAL = 10, S_JALR = 11;
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                         OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

  logic clk = 1'b0;
  logic reset, funct7b5, branch_cond, mem_ready;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [4:0] alu_control;
  logic [2:0] imm_src;
  logic [3:0] state_dbg;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  control_unit #(.PRINT_STATE(0)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .branch_cond(branch_cond), .mem_ready(mem_ready), .pc_write(pc_write),
    .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .imm_src(imm_src), .illegal_instr(illegal_instr),
    .state_dbg(state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (op=%b f3=%0d t=%0t)",
               name, act, exp, opcode, funct3, $time);
    end
  endtask

  function automatic bit is_known(input logic [6:0] op);
    return op inside {OP_LOAD, OP_STORE, OP_R, OP_I, OP_LUI, OP_AUIPC, OP_BR, OP_JAL, OP_JALR};
  endfunction

  // Expected ALU operation, chosen from the instruction's meaning
  function automatic logic [4:0] model_alu(input int s, input logic [6:0] op,
                                           input logic [2:0] f3, input logic f7);
    if (s == S_EXECR || (s == S_EXECI && op == OP_I)) begin
      case (f3)
        3'd0: return (s == S_EXECR && f7) ? 5'b00001 : 5'b00000;
        3'd1: return 5'b00110;
        3'd2: return 5'b01101;
        3'd3: return 5'b01011;
        3'd4: return 5'b00101;
        3'd5: return f7 ? 5'b00011 : 5'b00111;
        3'd6: return 5'b00100;
        default: return 5'b00010;
      endcase
    end
    if (s == S_BRANCH) begin
      case (f3)
        3'd0: return 5'b01001;
        3'd1: return 5'b01010;
        3'd4: return 5'b01101;
        3'd5: return 5'b10000;
        3'd6: return 5'b01011;
        3'd7: return 5'b01111;
        default: return 5'b00000;
      endcase
    end
    return 5'b00000;
  endfunction

  // {pc_write, ir_write, mem_write, reg_write, illegal_instr}
  function automatic logic [4:0] model_en(input int s, input logic [6:0] op,
                                          input logic [2:0] f3, input logic bc, input logic mr);
    logic bad_br;
    bad_br = (f3 == 3'd2) || (f3 == 3'd3);
    return {(s == S_FETCH && mr) || (s == S_BRANCH && bc && !bad_br) || (s == S_JAL),
            (s == S_FETCH && mr),
            (s == S_MEMWRITE),
            (s == S_MEMWB || s == S_ALUWB),
            (s == S_DECODE && !is_known(op)) || (s == S_BRANCH && bad_br)};
  endfunction

  // {adr_src, result_src, alu_src_a, alu_src_b, alu_control, imm_src}
  function automatic logic [14:0] model_dp(input int s, input logic [6:0] op,
                                           input logic [2:0] f3, input logic f7);
    logic a; logic [1:0] rs, sa, sb; logic [2:0] im;
    a  = (s == S_MEMREAD || s == S_MEMWRITE);
    rs = (s == S_FETCH) ? 2'd2 : (s == S_MEMWB) ? 2'd1 : 2'd0;
    case (s)
      S_DECODE, S_JAL:                     sa = 2'd1;
      S_MEMADR, S_EXECR, S_BRANCH, S_JALR: sa = 2'd2;
      S_EXECI: sa = (op == OP_LUI) ? 2'd3 : (op == OP_AUIPC) ? 2'd1 : 2'd2;
      default:                             sa = 2'd0;
    endcase
    case (s)
      S_FETCH, S_JAL:                      sb = 2'd2;
      S_DECODE, S_MEMADR, S_EXECI, S_JALR: sb = 2'd1;
      default:                             sb = 2'd0;
    endcase
    case (op)
      OP_STORE:         im = 3'd1;
      OP_BR:            im = 3'd2;
      OP_JAL:           im = 3'd3;
      OP_LUI, OP_AUIPC: im = 3'd4;
      default:          im = 3'd0;
    endcase
    return {a, rs, sa, sb, model_alu(s, op, f3, f7), im};
  endfunction

  // Run one instruction from FETCH back to FETCH, checking every cycle.
  // Stall states hold for the chosen number of mem_ready=0 cycles.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic bc, input int stall_n, input bit rnd,
                           output int cyc, output logic [4:0] alu2, output int pcw,
                           output int ill);
    int pq[$];
    int s, rem;
    bit stallable;
    pq = '{S_FETCH, S_DECODE};
    case (op)
      OP_LOAD:                 pq = {pq, S_MEMADR, S_MEMREAD, S_MEMWB};
      OP_STORE:                pq = {pq, S_MEMADR, S_MEMWRITE};
      OP_R:                    pq = {pq, S_EXECR, S_ALUWB};
      OP_I, OP_LUI, OP_AUIPC:  pq = {pq, S_EXECI, S_ALUWB};
      OP_BR:                   pq = {pq, S_BRANCH};
      OP_JAL:                  pq = {pq, S_JAL, S_ALUWB};
      OP_JALR:                 pq = {pq, S_JALR, S_JAL, S_ALUWB};
      default:                 pq = pq;
    endcase
    opcode = op; funct3 = f3; funct7b5 = f7; branch_cond = bc;
    cyc = 0; alu2 = 5'd0; pcw = 0; ill = 0; rem = -1;
    while (pq.size() > 0 && cyc < 100) begin
      s = pq[0];
      stallable = (s == S_FETCH || s == S_MEMREAD || s == S_MEMWRITE);
      if (rem < 0) begin
        if (!stallable)   rem = 0;
        else if (rnd)     rem = $urandom_range(0, stall_n);
        else              rem = (s == S_FETCH) ? 0 : stall_n;
      end
      mem_ready = (rem == 0);
      #1;
      check("state", 32'(state_dbg), 32'(s));
      check("enables", {27'd0, pc_write, ir_write, mem_write, reg_write, illegal_instr},
            {27'd0, model_en(s, op, f3, bc, mem_ready)});
      check("datapath", {17'd0, adr_src, result_src, alu_src_a, alu_src_b, alu_control, imm_src},
            {17'd0, model_dp(s, op, f3, f7)});
      if (cyc == 2) alu2 = alu_control;
      pcw += int'(pc_write);
      ill += int'(illegal_instr);
      if (rem == 0) begin
        void'(pq.pop_front());
        rem = -1;
      end else begin
        rem--;
      end
      cyc++;
      @(posedge clk); #1;
    end
    if (pq.size() > 0) check("timeout", 32'd1, 32'd0);
  endtask

  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic f7; logic bc;
    int cyc; logic [4:0] alu; int pcw; int ill;
  } vec_t;

  vec_t tbl[$];
  int cyc, pcw, ill;
  logic [4:0] alu2;
  logic [6:0] ops[13];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // op, f3, f7, bc, cycles, ALU code in third cycle, pc_write cycles, illegal pulses
    tbl.push_back('{OP_R,     3'd0, 1'b0, 1'b0, 4, 5'b00000, 1, 0}); // add
    tbl.push_back('{OP_R,     3'd0, 1'b1, 1'b0, 4, 5'b00001, 1, 0}); // sub
    tbl.push_back('{OP_R,     3'd5, 1'b1, 1'b0, 4, 5'b00011, 1, 0}); // sra
    tbl.push_back('{OP_R,     3'd2, 1'b0, 1'b0, 4, 5'b01101, 1, 0}); // slt
    tbl.push_back('{OP_R,     3'd3, 1'b0, 1'b0, 4, 5'b01011, 1, 0}); // sltu
    tbl.push_back('{OP_I,     3'd0, 1'b1, 1'b0, 4, 5'b00000, 1, 0}); // addi, no SUB
    tbl.push_back('{OP_I,     3'd5, 1'b0, 1'b0, 4, 5'b00111, 1, 0}); // srli
    tbl.push_back('{OP_I,     3'd4, 1'b0, 1'b0, 4, 5'b00101, 1, 0}); // xori
    tbl.push_back('{OP_LUI,   3'd3, 1'b1, 1'b0, 4, 5'b00000, 1, 0});
    tbl.push_back('{OP_AUIPC, 3'd7, 1'b0, 1'b0, 4, 5'b00000, 1, 0});
    tbl.push_back('{OP_LOAD,  3'd2, 1'b0, 1'b0, 5, 5'b00000, 1, 0});
    tbl.push_back('{OP_STORE, 3'd2, 1'b0, 1'b0, 4, 5'b00000, 1, 0});
    tbl.push_back('{OP_BR,    3'd0, 1'b0, 1'b1, 3, 5'b01001, 2, 0}); // beq taken
    tbl.push_back('{OP_BR,    3'd0, 1'b0, 1'b0, 3, 5'b01001, 1, 0}); // beq not taken
    tbl.push_back('{OP_BR,    3'd5, 1'b0, 1'b1, 3, 5'b10000, 2, 0}); // bge
    tbl.push_back('{OP_BR,    3'd7, 1'b0, 1'b1, 3, 5'b01111, 2, 0}); // bgeu
    tbl.push_back('{OP_BR,    3'd2, 1'b0, 1'b1, 3, 5'b00000, 1, 1}); // bad funct3
    tbl.push_back('{OP_JAL,   3'd0, 1'b0, 1'b0, 4, 5'b00000, 2, 0});
    tbl.push_back('{OP_JALR,  3'd0, 1'b0, 1'b0, 5, 5'b00000, 2, 0});
    tbl.push_back('{7'h7F,    3'd0, 1'b0, 1'b0, 2, 5'b00000, 1, 1}); // unknown opcode

    reset = 1'b1; opcode = OP_R; funct3 = 3'd0; funct7b5 = 1'b0;
    branch_cond = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(state_dbg), 32'(S_FETCH));
    check("reset_enables", {27'd0, pc_write, ir_write, mem_write, reg_write, illegal_instr}, 32'd0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      run_instr(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].bc, 0, 1'b0, cyc, alu2, pcw, ill);
      check($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(tbl[i].cyc));
      check($sformatf("vec%0d_alu", i), 32'(alu2), 32'(tbl[i].alu));
      check($sformatf("vec%0d_pcw", i), 32'(pcw), 32'(tbl[i].pcw));
      check($sformatf("vec%0d_ill", i), 32'(ill), 32'(tbl[i].ill));
    end

    // Load with three stall cycles in MEMREAD, store with two in MEMWRITE
    run_instr(OP_LOAD, 3'd2, 1'b0, 1'b0, 3, 1'b0, cyc, alu2, pcw, ill);
    check("load_stall_cycles", 32'(cyc), 32'd8);
    run_instr(OP_STORE, 3'd2, 1'b0, 1'b0, 2, 1'b0, cyc, alu2, pcw, ill);
    check("store_stall_cycles", 32'(cyc), 32'd6);

    // Reset during a MEMWRITE stall
    opcode = OP_STORE; mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0; #1;
    check("sw_stall_state", 32'(state_dbg), 32'(S_MEMWRITE));
    check("sw_stall_mem_write", 32'(mem_write), 32'd1);
    @(posedge clk); #1;
    check("sw_stall_hold", 32'(state_dbg), 32'(S_MEMWRITE));
    reset = 1'b1; #1;
    check("sw_reset_mem_write", 32'(mem_write), 32'd0);
    @(posedge clk); #1;
    check("sw_reset_state", 32'(state_dbg), 32'(S_FETCH));
    reset = 1'b0; mem_ready = 1'b1;

    // Reset from JALR returns to FETCH
    opcode = OP_JALR;
    repeat (2) begin @(posedge clk); #1; end
    check("jalr_state", 32'(state_dbg), 32'(S_JALR));
    reset = 1'b1;
    @(posedge clk); #1;
    check("jalr_reset_state", 32'(state_dbg), 32'(S_FETCH));
    reset = 1'b0;

    // Randomized instructions and memory stalls
    ops = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_LUI, OP_AUIPC, OP_BR, OP_JAL, OP_JALR,
            7'h7F, 7'h00, 7'b0001111, 7'b1110011};
    for (int k = 0; k < 200; k++) begin
      run_instr(ops[$urandom_range(0, 12)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 3, 1'b1, cyc, alu2, pcw, ill);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
